// File: rtl/jt1943_objscan.sv
// jt1943_objscan: per-line sprite scanner that fills a ping-pong line table for jt1943_objdraw.
// Define JT1943_OBJSCAN_OVF_EN to enable the sticky obj_ovf overflow flag.
module jt1943_objscan #(
  parameter int OBJMAX = 31,
  parameter int NOBJ   = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       HINIT,
  input  logic [7:0] V,
  output logic [8:0] objram_addr,
  input  logic [7:0] objram_data,
  input  logic [4:0] objcnt,
  input  logic [3:0] pxlcnt,
  output logic [7:0] objbuf_data,
  output logic       obj_ovf
);
  localparam logic [4:0] SLOT_MAX = 5'(OBJMAX);
  localparam logic [6:0] OBJ_LAST = 7'(NOBJ - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, TEST, COPY, NEXT, DONE} state_t;

  state_t     state_q, state_d;
  logic       bank_q, bank_d;
  logic [4:0] cnt_wr_q, cnt_wr_d, cnt_rd_q, cnt_rd_d;
  logic [6:0] obj_q, obj_d;
  logic [2:0] cpy_q, cpy_d;
  logic [7:0] vt_q, vt_d;
  logic [8:0] addr_q, addr_d;
  logic       ovf_set;
  logic       wr_en;
  logic [4:0] wr_slot;
  logic [1:0] wr_byte;
  logic [7:0] objy, ydiff;
  logic       hit;
  logic [7:0] rd_q, rd_d;
  logic [7:0] tbl [256];
  logic       unused_pxl;

  assign unused_pxl  = ^pxlcnt[3:2];
  assign objram_addr = addr_q;
  assign objbuf_data = rd_q;

  // Same wrap-around zone test as the draw side
  assign objy  = objram_data - 8'd2;
  assign ydiff = vt_q - objy;
  assign hit   = ydiff < 8'd16;

  // Byte k lands two edges after its address was registered (cpy = k+1)
  assign wr_slot = cnt_wr_q + 5'd1;
  assign wr_byte = cpy_q[1:0] - 2'd1;

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    cnt_wr_d = cnt_wr_q;
    cnt_rd_d = cnt_rd_q;
    obj_d    = obj_q;
    cpy_d    = cpy_q;
    vt_d     = vt_q;
    addr_d   = addr_q;
    ovf_set  = 1'b0;
    wr_en    = 1'b0;
    if (HINIT) begin
      bank_d   = ~bank_q;
      cnt_rd_d = cnt_wr_q;
      cnt_wr_d = 5'd0;
      vt_d     = V + 8'd1;
      obj_d    = OBJ_LAST;
      state_d  = ADDR;
    end else begin
      case (state_q)
        ADDR: begin
          addr_d  = {obj_q, 2'd2};
          state_d = WAIT;
        end
        WAIT: state_d = TEST;
        TEST: begin
          if (!hit) begin
            state_d = NEXT;
          end else if (cnt_wr_q == SLOT_MAX) begin
            ovf_set = 1'b1;
            state_d = NEXT;
          end else begin
            addr_d  = {obj_q, 2'd0};
            cpy_d   = 3'd0;
            state_d = COPY;
          end
        end
        COPY: begin
          if (cpy_q < 3'd3) addr_d = {obj_q, cpy_q[1:0] + 2'd1};
          wr_en = (cpy_q != 3'd0);
          cpy_d = cpy_q + 3'd1;
          if (cpy_q == 3'd4) begin
            cnt_wr_d = cnt_wr_q + 5'd1;
            state_d  = NEXT;
          end
        end
        NEXT: begin
          if (obj_q == 7'd0) begin
            state_d = DONE;
          end else begin
            obj_d   = obj_q - 7'd1;
            state_d = ADDR;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bank_q   <= 1'b0;
      cnt_wr_q <= 5'd0;
      cnt_rd_q <= 5'd0;
      obj_q    <= 7'd0;
      cpy_q    <= 3'd0;
      vt_q     <= 8'd0;
      addr_q   <= 9'd0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      cnt_wr_q <= cnt_wr_d;
      cnt_rd_q <= cnt_rd_d;
      obj_q    <= obj_d;
      cpy_q    <= cpy_d;
      vt_q     <= vt_d;
      addr_q   <= addr_d;
    end
  end

`ifdef JT1943_OBJSCAN_OVF_EN
  logic ovf_q;
  assign obj_ovf = ovf_q;
  always_ff @(posedge clk) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (HINIT)   ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf_set;
  assign obj_ovf    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) tbl[{bank_q, wr_slot, wr_byte}] <= objram_data;
  end

  // Empty slots read as an object parked outside the zone and off screen
  always_comb begin
    rd_d = tbl[{~bank_q, objcnt, pxlcnt[1:0]}];
    if (objcnt == 5'd0 || objcnt > cnt_rd_q) begin
      case (pxlcnt[1:0])
        2'd2:    rd_d = vt_q + 8'h40;
        2'd3:    rd_d = 8'hF8;
        default: rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= 8'd0;
    else        rd_q <= rd_d;
  end
endmodule

// File: tb/tb_jt1943_objscan.sv
// Bench for jt1943_objscan: object RAM model plus a per-line list model of the expected table.
module tb_jt1943_objscan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       HINIT = 1'b0;
  logic [7:0] V = 8'd0;
  logic [8:0] objram_addr;
  logic [7:0] objram_data;
  logic [4:0] objcnt = 5'd0;
  logic [3:0] pxlcnt = 4'd0;
  logic [7:0] objbuf_data;
  logic       obj_ovf;

  int          nvec = 0;
  int          nmis = 0;
  logic [7:0]  ram [512];
  logic [31:0] wr_q [$];
  logic [31:0] rd_q [$];
  bit          wr_ovf = 1'b0;
  logic [7:0]  cur_vt = 8'd0;

  jt1943_objscan dut (
    .clk(clk), .rst_n(rst_n), .HINIT(HINIT), .V(V),
    .objram_addr(objram_addr), .objram_data(objram_data),
    .objcnt(objcnt), .pxlcnt(pxlcnt),
    .objbuf_data(objbuf_data), .obj_ovf(obj_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) objram_data <= ram[objram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_obj(input int o, input logic [7:0] y);
    ram[o*4+0] = {1'b1, 7'(o)};
    ram[o*4+1] = 8'($urandom);
    ram[o*4+2] = y;
    ram[o*4+3] = 8'($urandom);
  endtask

  task automatic fill_bg(input logic [7:0] y);
    for (int o = 0; o < 128; o++) set_obj(o, y);
  endtask

  // Which objects cover line vt, scanned high index first, first 31 kept
  task automatic model_scan(input logic [7:0] vt);
    wr_q.delete();
    wr_ovf = 1'b0;
    for (int o = 127; o >= 0; o--) begin
      logic [7:0] objy;
      logic [7:0] d;
      objy = ram[o*4+2] - 8'd2;
      d = vt - objy;
      if (d < 8'd16) begin
        if (wr_q.size() < 31) wr_q.push_back({ram[o*4+3], ram[o*4+2], ram[o*4+1], ram[o*4+0]});
        else wr_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] exp_byte(input int slot, input int b);
    logic [31:0] w;
    if (slot == 0 || slot > rd_q.size()) begin
      case (b)
        2:       return cur_vt + 8'h40;
        3:       return 8'hF8;
        default: return 8'h00;
      endcase
    end
    w = rd_q[slot-1];
    return w[8*b +: 8];
  endfunction

  task automatic hinit(input logic [7:0] v);
    @(negedge clk);
    V = v;
    HINIT = 1'b1;
    @(negedge clk);
    HINIT = 1'b0;
    rd_q = wr_q;
    cur_vt = v + 8'd1;
    model_scan(cur_vt);
  endtask

  task automatic rd(input int slot, input int b, output logic [7:0] d);
    @(negedge clk);
    objcnt = 5'(slot);
    pxlcnt = {2'($urandom_range(0, 3)), 2'(b)};
    @(posedge clk);
    #1 d = objbuf_data;
  endtask

  task automatic check_table(input string tag);
    logic [7:0] d;
    for (int s = 0; s < 32; s++)
      for (int b = 0; b < 4; b++) begin
        rd(s, b, d);
        chk($sformatf("%s slot%0d byte%0d", tag, s, b), {24'd0, d}, {24'd0, exp_byte(s, b)});
      end
  endtask

  task automatic run_line(input logic [7:0] v, input string tag);
    hinit(v);
    repeat (800) @(negedge clk);
    check_table(tag);
`ifdef JT1943_OBJSCAN_OVF_EN
    chk({tag, " ovf"}, {31'd0, obj_ovf}, {31'd0, wr_ovf});
`else
    chk({tag, " ovf"}, {31'd0, obj_ovf}, 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] d;
    int nvis;
    bit gap;
    fill_bg(8'hF0);

    repeat (3) @(negedge clk);
    chk("rst objbuf_data", {24'd0, objbuf_data}, 32'd0);
    chk("rst obj_ovf", {31'd0, obj_ovf}, 32'd0);
    chk("rst objram_addr", {23'd0, objram_addr}, 32'd0);
    rst_n = 1'b1;

    // single object 5 on line 0x40
    set_obj(5, 8'h40);
    run_line(8'h3F, "first");
    run_line(8'h40, "obj5");

    // zone edges: diff 2 hits, diff 17 misses
    fill_bg(8'hF0);
    set_obj(10, 8'h50);
    set_obj(11, 8'h41);
    run_line(8'h4F, "edge_scan");
    run_line(8'h80, "edge");

    // object straddling the top wraps through 0xFF
    fill_bg(8'hF0);
    set_obj(20, 8'h01);
    set_obj(21, 8'h01);
    run_line(8'h00, "wrap_scan");
    run_line(8'h80, "wrap");

    // 40 objects in zone overflows the 31 slots
    fill_bg(8'hF0);
    for (int o = 127; o >= 88; o--) set_obj(o, 8'h62);
    run_line(8'h60, "ovf_scan");
    run_line(8'h80, "ovf");

    // random object RAM and lines
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
      run_line(8'($urandom), $sformatf("rand%0d", k));
    end
    run_line(8'h80, "rand_last");

    // line cut short: only completed slots may show, as a prefix of the hit list
    fill_bg(8'hF0);
    for (int o = 90; o >= 81; o--) set_obj(o, 8'h62);
    hinit(8'h60);
    repeat (198) @(negedge clk);
    hinit(8'h80);
    nvis = 0;
    gap = 1'b0;
    for (int s = 1; s < 32; s++) begin
      rd(s, 0, d);
      if (d != 8'd0 && !gap) nvis++;
      else gap = 1'b1;
    end
    chk("abort visible range", {31'd0, (nvis >= 1 && nvis <= 9)}, 32'd1);
    while (rd_q.size() > nvis) void'(rd_q.pop_back());
    check_table("abort");

    // reset in the middle of copying the first hit
    fill_bg(8'hF0);
    for (int o = 127; o >= 120; o--) set_obj(o, 8'h62);
    hinit(8'h60);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst objbuf_data", {24'd0, objbuf_data}, 32'd0);
    chk("midrst objram_addr", {23'd0, objram_addr}, 32'd0);
    chk("midrst obj_ovf", {31'd0, obj_ovf}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wr_q.delete();
    rd_q.delete();
    wr_ovf = 1'b0;
    repeat (50) @(negedge clk);
    for (int s = 1; s < 4; s++) begin
      rd(s, 0, d); chk($sformatf("postrst slot%0d byte0", s), {24'd0, d}, 32'd0);
      rd(s, 1, d); chk($sformatf("postrst slot%0d byte1", s), {24'd0, d}, 32'd0);
      rd(s, 3, d); chk($sformatf("postrst slot%0d byte3", s), {24'd0, d}, 32'hF8);
    end
    run_line(8'h60, "postrst_scan");
    run_line(8'h80, "postrst");

    // slot 0 is blank and reads take one clock
    @(negedge clk);
    objcnt = 5'd0;
    pxlcnt = 4'd0;
    @(posedge clk);
    #1 chk("lat slot0", {24'd0, objbuf_data}, 32'd0);
    @(negedge clk);
    objcnt = 5'd1;
    #2 chk("lat hold", {24'd0, objbuf_data}, 32'd0);
    @(posedge clk);
    #1 chk("lat slot1", {24'd0, objbuf_data}, {24'd0, exp_byte(1, 0)});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
